lock_code_datapath: RTL and testbench

Keypad/ENTER front end and code datapath for the combination-lock FSM. It debounces the raw ENTER button into a one-cycle `E` strobe and assembles keypad digits into an entry buffer. It captures the password on `savePW` and the attempt on `saveAT`, and drives `M` by comparing the entry buffer with the stored password. It also counts failed attempts and imposes a timed lockout that suppresses `E`.

---
 rtl/lock_pkg.sv | 24 ++
 rtl/enter_debounce.sv | 59 +++++
 rtl/lock_code_datapath.sv | 133 +++++++++++++
 tb/tb_lock_code_datapath.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// ============================================================================
//  Module      : lock_pkg
//  Description : Shared types and defaults for the combination-lock datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam int DEF_DIGITS  = 4;
    localparam int DEF_DIGIT_W = 4;

    typedef enum logic [1:0] {
        OPEN   = 2'b00,
        SAVEPW = 2'b01,
        LOCKED = 2'b10,
        SAVEAT = 2'b11
    } lock_state_t;

    typedef logic [DEF_DIGITS*DEF_DIGIT_W-1:0] code_t;

endpackage

`default_nettype wire

// File: rtl/enter_debounce.sv
// ============================================================================
//  Module      : enter_debounce
//  Description : Synchronises and debounces the ENTER button; one-cycle press
//                strobe, suppressed while the lockout timer runs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module enter_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK50,
    input  logic reset,
    input  logic enter_n,
    input  logic lockout,
    output logic E
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_level_d;
    logic [c_DB_W-1:0] r_cnt;
    logic              r_E;

    // Everything resets to the released (high) level so no press is seen
    // out of reset.
    always_ff @(posedge CLK50) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_E       <= 1'b0;
        end else begin
            r_sync1   <= enter_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_E       <= r_level_d & ~r_level & ~lockout;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_DB_W'(1);
            end
        end
    end

    assign E = r_E;

endmodule

`default_nettype wire

// File: rtl/lock_code_datapath.sv
// ============================================================================
//  Module      : lock_code_datapath
//  Description : Keypad entry buffer, password/attempt capture, match compare,
//                failed-attempt counting and timed lockout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lock_code_datapath #(
    parameter int DIGITS          = lock_pkg::DEF_DIGITS,
    parameter int DIGIT_W         = lock_pkg::DEF_DIGIT_W,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 150000000
) (
    input  logic                           CLK50,
    input  logic                           reset,
    input  logic                           enter_n,
    input  logic                           key_valid,
    input  logic [DIGIT_W-1:0]             key_digit,
    input  logic                           savePW,
    input  logic                           saveAT,
    input  logic                           LOCKED,
    output logic                           E,
    output logic                           M,
    output logic [DIGITS*DIGIT_W-1:0]      attempt,
    output logic [$clog2(DIGITS+1)-1:0]    entry_count,
    output logic [$clog2(MAX_FAILS+1)-1:0] fails,
    output logic                           lockout
);

    localparam int c_CODE_W = DIGITS * DIGIT_W;
    localparam int c_CNT_W  = $clog2(DIGITS + 1);
    localparam int c_FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int c_TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(DIGITS);
    localparam logic [c_FAIL_W-1:0] c_FAIL_LAST = c_FAIL_W'(MAX_FAILS - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_LOAD  = c_TMR_W'(LOCKOUT_CYCLES - 1);

    logic [c_CODE_W-1:0] r_entry;
    logic [c_CODE_W-1:0] r_password;
    logic [c_CODE_W-1:0] r_attempt;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_FAIL_W-1:0] r_fails;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_lockout;
    logic                w_E;
    logic                w_match;
    logic                w_accept;

    enter_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_debounce (
        .CLK50   (CLK50),
        .reset   (reset),
        .enter_n (enter_n),
        .lockout (r_lockout),
        .E       (w_E)
    );

    // Entry must stay frozen from E through the save strobe so M is stable.
    assign w_accept = key_valid & ~w_E & ~savePW & ~saveAT;
    assign w_match  = (r_entry == r_password);

    always_ff @(posedge CLK50) begin
        if (reset) begin
            r_entry <= '0;
            r_count <= '0;
        end else if (savePW || saveAT) begin
            r_entry <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_entry <= {r_entry[c_CODE_W-DIGIT_W-1:0], key_digit};
            if (r_count != c_CNT_MAX) begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK50) begin
        if (reset) begin
            r_password <= '0;
            r_attempt  <= '0;
        end else if (savePW) begin
            r_password <= r_entry;
        end else if (saveAT) begin
            r_attempt <= r_entry;
        end
    end

    // A lockout start in the same cycle overrides the timer update above it.
    always_ff @(posedge CLK50) begin
        if (reset) begin
            r_fails   <= '0;
            r_timer   <= '0;
            r_lockout <= 1'b0;
        end else begin
            if (r_lockout) begin
                if (r_timer == '0) begin
                    r_lockout <= 1'b0;
                end else begin
                    r_timer <= r_timer - c_TMR_W'(1);
                end
            end
            if (savePW) begin
                r_fails <= '0;
            end else if (saveAT) begin
                if (w_match) begin
                    r_fails <= '0;
                end else if (LOCKED) begin
                    if (r_fails == c_FAIL_LAST) begin
                        r_fails   <= '0;
                        r_lockout <= 1'b1;
                        r_timer   <= c_TMR_LOAD;
                    end else begin
                        r_fails <= r_fails + c_FAIL_W'(1);
                    end
                end
            end
        end
    end

    assign E           = w_E;
    assign M           = w_match;
    assign attempt     = r_attempt;
    assign entry_count = r_count;
    assign fails       = r_fails;
    assign lockout     = r_lockout;

endmodule

`default_nettype wire

// File: tb/tb_lock_code_datapath.sv
// ============================================================================
//  Module      : tb_lock_code_datapath
//  Description : Scoreboard bench for the lock code datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lock_code_datapath;

    localparam int c_DIGITS  = 4;
    localparam int c_DIGIT_W = 4;

    logic        CLK50     = 1'b0;
    logic        reset     = 1'b1;
    logic        enter_n   = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'h0;
    logic        savePW    = 1'b0;
    logic        saveAT    = 1'b0;
    logic        LOCKED    = 1'b0;
    logic        E;
    logic        M;
    logic [15:0] attempt;
    logic [2:0]  entry_count;
    logic [1:0]  fails;
    logic        lockout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    lock_code_datapath #(
        .DIGITS          (c_DIGITS),
        .DIGIT_W         (c_DIGIT_W),
        .DEBOUNCE_CYCLES (4),
        .MAX_FAILS       (3),
        .LOCKOUT_CYCLES  (10)
    ) dut (
        .CLK50       (CLK50),
        .reset       (reset),
        .enter_n     (enter_n),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .savePW      (savePW),
        .saveAT      (saveAT),
        .LOCKED      (LOCKED),
        .E           (E),
        .M           (M),
        .attempt     (attempt),
        .entry_count (entry_count),
        .fails       (fails),
        .lockout     (lockout)
    );

    always #5 CLK50 = ~CLK50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
    endtask

    // Returns in the cycle where E is high (or after the budget expires).
    task automatic press_until_E();
        int lat;
        lat = -1;
        enter_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (E) begin
                lat = i;
                break;
            end
        end
        expect_v("E_latency", 7);
        observe(lat);
    endtask

    task automatic release_enter();
        enter_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic attempt_seq(input logic [15:0] c);
        enter_code(c);
        press_until_E();
        saveAT = 1'b1;
        tick();
        saveAT = 1'b0;
        release_enter();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int first;
        int lock_cnt;

        repeat (3) tick();
        reset = 1'b0;
        expect_v("rst_E", 0);        observe(E);
        expect_v("rst_M", 1);        observe(M);
        expect_v("rst_attempt", 0);  observe(attempt);
        expect_v("rst_count", 0);    observe(entry_count);
        expect_v("rst_fails", 0);    observe(fails);
        expect_v("rst_lockout", 0);  observe(lockout);

        // Short glitch must not produce a strobe.
        enter_n = 1'b0;
        cnt = 0;
        repeat (3) begin tick(); if (E) cnt++; end
        enter_n = 1'b1;
        repeat (12) begin tick(); if (E) cnt++; end
        expect_v("glitch_E", 0);
        observe(cnt);

        // Long hold: one pulse at cycle 7, none after.
        enter_n = 1'b0;
        cnt = 0;
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (E) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        expect_v("hold_first", 7);   observe(first);
        expect_v("hold_pulses", 1);  observe(cnt);
        release_enter();

        // Overflow: five digits keep the last four.
        for (int d = 1; d <= 5; d++) key(4'(d));
        expect_v("ovf_count", 4);    observe(entry_count);
        saveAT = 1'b1;
        tick();
        saveAT = 1'b0;
        expect_v("ovf_attempt", 16'h2345); observe(attempt);
        expect_v("ovf_clear", 0);          observe(entry_count);

        // Set the password, then unlock with it.
        enter_code(16'h1234);
        press_until_E();
        savePW = 1'b1;
        tick();
        savePW = 1'b0;
        expect_v("pw_clear", 0);     observe(entry_count);
        expect_v("pw_M_empty", 0);   observe(M);
        release_enter();
        LOCKED = 1'b1;
        enter_code(16'h1234);
        press_until_E();
        saveAT = 1'b1;
        expect_v("unlock_M", 1);     observe(M);
        tick();
        saveAT = 1'b0;
        expect_v("unlock_attempt", 16'h1234); observe(attempt);
        expect_v("unlock_fails", 0);          observe(fails);
        release_enter();

        // Three wrong attempts lead to lockout.
        attempt_seq(16'h0000);
        expect_v("fails_1", 1);      observe(fails);
        attempt_seq(16'h0000);
        expect_v("fails_2", 2);      observe(fails);
        enter_code(16'h0000);
        enter_n = 1'b0;
        repeat (5) tick();
        enter_n = 1'b1;
        tick();
        tick();
        expect_v("att3_E", 1);       observe(E);
        saveAT = 1'b1;
        tick();
        saveAT = 1'b0;
        expect_v("lock_set", 1);     observe(lockout);
        expect_v("lock_fails", 0);   observe(fails);
        // A press debounced inside the lockout window is dropped.
        lock_cnt = 1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) enter_n = 1'b0;
            tick();
            if (E) cnt++;
            if (lockout) lock_cnt++;
            else break;
        end
        expect_v("lock_len", 10);    observe(lock_cnt);
        expect_v("lock_E", 0);       observe(cnt);
        release_enter();
        press_until_E();
        release_enter();

        // Keys during E and saveAT are dropped.
        enter_code(16'h1234);
        press_until_E();
        key_valid = 1'b1;
        key_digit = 4'h9;
        tick();
        key_digit = 4'h8;
        saveAT = 1'b1;
        expect_v("kds_M", 1);        observe(M);
        tick();
        saveAT = 1'b0;
        key_valid = 1'b0;
        expect_v("kds_attempt", 16'h1234); observe(attempt);
        expect_v("kds_count", 0);          observe(entry_count);
        release_enter();

        // Reset in the middle of a lockout.
        attempt_seq(16'h0000);
        attempt_seq(16'h0000);
        enter_code(16'h0000);
        press_until_E();
        saveAT = 1'b1;
        tick();
        saveAT = 1'b0;
        expect_v("rl_lock", 1);      observe(lockout);
        enter_n = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        expect_v("rl_lockout", 0);   observe(lockout);
        expect_v("rl_M", 1);         observe(M);
        expect_v("rl_count", 0);     observe(entry_count);
        expect_v("rl_fails", 0);     observe(fails);
        expect_v("rl_attempt", 0);   observe(attempt);
        reset = 1'b0;
        cnt = 0;
        repeat (10) begin tick(); if (E) cnt++; end
        expect_v("rl_no_E", 0);      observe(cnt);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover: observed %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
